// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants, operand classification and divider states
package fp32_pkg;

   localparam int          EXP_MAX   = 255;
   localparam int          EXP_BIAS  = 127;
   localparam logic [23:0] QNAN_FRAC = 24'h800000;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   // Denormals are flushed, so any zero exponent counts as zero.
   function automatic logic is_zero(input logic [7:0] e);
      return e == 8'd0;
   endfunction

   function automatic logic is_inf(input logic [7:0] e, input logic [22:0] f);
      return (e == 8'(EXP_MAX)) && (f == 23'd0);
   endfunction

endpackage

// File: rtl/mant_div_step.sv
// rtl/mant_div_step.sv - one combinational radix-2 restoring division step
module mant_div_step (
   input  logic [25:0] r,
   input  logic [23:0] d,
   output logic [25:0] r_next,
   output logic        q
);

   logic [25:0] diff;

   // R stays below 2*D, so the bit shifted out of the top is always zero.
   always_comb begin
      q      = (r >= {2'b00, d});
      diff   = r - {2'b00, d};
      r_next = q ? {diff[24:0], 1'b0} : {r[24:0], 1'b0};
   end

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative FP32 divider with start/busy/done handshake
module fdiv_iter #(
   parameter int EXP_BIAS = fp32_pkg::EXP_BIAS,
   parameter int QBITS    = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        A_sign,
   input  logic [7:0]  A_exp,
   input  logic [22:0] A_frac,
   input  logic        B_sign,
   input  logic [7:0]  B_exp,
   input  logic [22:0] B_frac,
   output logic        busy,
   output logic        done,
   output logic        sign,
   output logic [7:0]  exp,
   output logic [23:0] frac,
   output logic        error,
   output logic        overflow,
   output logic        div_by_zero
);

   import fp32_pkg::*;

   localparam int CW = $clog2(QBITS);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [25:0]       rem, rem_next;
   logic [23:0]       dvs;
   logic [QBITS-1:0]  quo;
   logic [7:0]        a_exp, b_exp;
   logic              res_sign, q_bit, first;
   logic              a_zero, b_zero, a_inf, b_inf, nan_c, special;
   logic signed [9:0] e_norm;
   logic [23:0]       mant;

   mant_div_step u_step (
      .r      (rem),
      .d      (dvs),
      .r_next (rem_next),
      .q      (q_bit)
   );

   // Classification is only meaningful in the first DIV cycle, while rem still holds {1,A_frac}.
   assign first   = (state == DIV) && (cnt == CW'(QBITS - 1));
   assign a_zero  = is_zero(a_exp);
   assign b_zero  = is_zero(b_exp);
   assign a_inf   = is_inf(a_exp, rem[22:0]);
   assign b_inf   = is_inf(b_exp, dvs[22:0]);
   assign nan_c   = (a_inf && b_inf) || (a_zero && b_zero);
   assign special = nan_c || a_inf || b_inf || a_zero || b_zero;

   assign mant   = quo[QBITS-1] ? quo[QBITS-1 -: 24] : quo[QBITS-2 -: 24];
   assign e_norm = {2'b00, a_exp} - {2'b00, b_exp} + 10'(EXP_BIAS) - {9'd0, ~quo[QBITS-1]};

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DIV;
         DIV: begin
            if (first && special) state_nxt = DONE;
            else if (cnt == '0)   state_nxt = NORM;
         end
         NORM:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         rem         <= '0;
         dvs         <= '0;
         quo         <= '0;
         a_exp       <= '0;
         b_exp       <= '0;
         res_sign    <= 1'b0;
         sign        <= 1'b0;
         exp         <= '0;
         frac        <= '0;
         error       <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_exp       <= A_exp;
               b_exp       <= B_exp;
               res_sign    <= A_sign ^ B_sign;
               rem         <= {3'b001, A_frac};
               dvs         <= {1'b1, B_frac};
               cnt         <= CW'(QBITS - 1);
               error       <= 1'b0;
               overflow    <= 1'b0;
               div_by_zero <= 1'b0;
            end
            DIV: begin
               if (first && special) begin
                  sign <= res_sign;
                  if (nan_c) begin
                     exp   <= 8'(EXP_MAX);
                     frac  <= QNAN_FRAC;
                     error <= 1'b1;
                  end else if (a_inf) begin
                     exp  <= 8'(EXP_MAX);
                     frac <= '0;
                  end else if (b_inf) begin
                     exp  <= '0;
                     frac <= '0;
                  end else if (b_zero) begin
                     exp         <= 8'(EXP_MAX);
                     frac        <= '0;
                     div_by_zero <= 1'b1;
                  end else begin
                     exp  <= '0;
                     frac <= '0;
                  end
               end else begin
                  rem <= rem_next;
                  quo <= {quo[QBITS-2:0], q_bit};
                  cnt <= cnt - 1'b1;
               end
            end
            NORM: begin
               sign <= res_sign;
               if (e_norm >= $signed(10'(EXP_MAX))) begin
                  exp      <= 8'(EXP_MAX);
                  frac     <= '0;
                  overflow <= 1'b1;
               end else if (e_norm <= 10'sd0) begin
                  exp  <= '0;
                  frac <= '0;
               end else begin
                  exp  <= e_norm[7:0];
                  frac <= mant;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
